// File: rtl/pc_imem_fetch_if.sv
// ============================================================================
// Module   : pc_imem_fetch_if
// Purpose  : Next-PC / instruction bus between fetch stage and datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_imem_fetch_if;
  logic [31:0] PC_INPUT;
  logic [31:0] instruction_OUTPUT;

  modport master (output PC_INPUT, input instruction_OUTPUT);
  modport slave  (input PC_INPUT, output instruction_OUTPUT);
endinterface

`default_nettype wire

// File: rtl/pc_imem_fetch.sv
// ============================================================================
// Module   : pc_imem_fetch
// Purpose  : PC register feeding a word-addressed combinational instruction ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_imem_fetch #(
  parameter int DEPTH = 64
) (
  input  wire logic         clk,
  input  wire logic         reset,
  pc_imem_fetch_if.slave    bus
);

  localparam logic [31:0] c_DEPTH = 32'(DEPTH);

  logic [31:0] r_pc;
  logic [31:0] w_instr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= 32'd0;
    end else begin
      r_pc <= bus.PC_INPUT;
    end
  end

  // Addresses at or beyond DEPTH read as nop; there is no wrap-around.
  always_comb begin
    w_instr = 32'h0000_0000;
    if (r_pc < c_DEPTH) begin
      case (r_pc)
        32'd0:   w_instr = 32'h0022_1820;
        32'd1:   w_instr = 32'h2109_000A;
        32'd2:   w_instr = 32'h0085_3022;
        32'd3:   w_instr = 32'h0022_3824;
        32'd4:   w_instr = 32'h0022_4025;
        32'd5:   w_instr = 32'h0022_502A;
        32'd6:   w_instr = 32'h8C0B_0004;
        32'd7:   w_instr = 32'hAC0B_0008;
        32'd8:   w_instr = 32'h1022_0002;
        32'd9:   w_instr = 32'h302C_00FF;
        32'd10:  w_instr = 32'h342D_0F0F;
        32'd11:  w_instr = 32'h282E_0005;
        default: w_instr = 32'h0000_0000;
      endcase
    end
  end

  assign bus.instruction_OUTPUT = w_instr;

endmodule

`default_nettype wire

// File: tb/tb_pc_imem_fetch.sv
// ============================================================================
// Module   : tb_pc_imem_fetch
// Purpose  : Self-checking bench for pc_imem_fetch (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_imem_fetch;

  typedef struct {
    logic [31:0] pc_in;
    logic [31:0] exp_instr;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  logic [31:0] sb_q[$];
  vec_t vecs[21];

  pc_imem_fetch_if bus ();

  pc_imem_fetch #(.DEPTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: instruction_OUTPUT=%08h (opcode %0d rs %0d rt %0d), required %08h",
               name, act, act[31:26], act[25:21], act[20:16], exp);
    end
  endtask

  // Drive a next-PC, record the expected fetch, then compare just after the edge.
  task automatic step(input logic [31:0] pc_in, input logic [31:0] exp, input string name);
    logic [31:0] want;
    bus.PC_INPUT = pc_in;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: scoreboard empty, required one pending entry", name);
    end else begin
      want = sb_q.pop_front();
      check(name, bus.instruction_OUTPUT, want);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Sequential fetch 1..15, then jumps, then out-of-range handling.
    vecs[0]  = '{32'd1,  32'h2109_000A};
    vecs[1]  = '{32'd2,  32'h0085_3022};
    vecs[2]  = '{32'd3,  32'h0022_3824};
    vecs[3]  = '{32'd4,  32'h0022_4025};
    vecs[4]  = '{32'd5,  32'h0022_502A};
    vecs[5]  = '{32'd6,  32'h8C0B_0004};
    vecs[6]  = '{32'd7,  32'hAC0B_0008};
    vecs[7]  = '{32'd8,  32'h1022_0002};
    vecs[8]  = '{32'd9,  32'h302C_00FF};
    vecs[9]  = '{32'd10, 32'h342D_0F0F};
    vecs[10] = '{32'd11, 32'h282E_0005};
    vecs[11] = '{32'd12, 32'h0000_0000};
    vecs[12] = '{32'd13, 32'h0000_0000};
    vecs[13] = '{32'd14, 32'h0000_0000};
    vecs[14] = '{32'd15, 32'h0000_0000};
    vecs[15] = '{32'd9,  32'h302C_00FF};
    vecs[16] = '{32'd1,  32'h2109_000A};
    vecs[17] = '{32'd6,  32'h8C0B_0004};
    vecs[18] = '{32'd64, 32'h0000_0000};
    vecs[19] = '{32'hFFFF_FFFF, 32'h0000_0000};
    vecs[20] = '{32'd2,  32'h0085_3022};

    // Reset held across edges ignores PC_INPUT.
    reset = 1'b1;
    bus.PC_INPUT = 32'd5;
    #1;
    check("reset_initial", bus.instruction_OUTPUT, 32'h0022_1820);
    step(32'd5, 32'h0022_1820, "reset_edge1");
    step(32'd5, 32'h0022_1820, "reset_edge2");
    reset = 1'b0;
    step(32'd5, 32'h0022_502A, "reset_release");

    // Return to PC 0 and run the table.
    reset = 1'b1;
    #1;
    check("seq_start", bus.instruction_OUTPUT, 32'h0022_1820);
    reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].pc_in, vecs[i].exp_instr, $sformatf("vec%0d", i));
    end

    // Asynchronous reset pulse between edges.
    step(32'd7, 32'hAC0B_0008, "async_pre");
    #2;
    reset = 1'b1;
    #1;
    check("async_during", bus.instruction_OUTPUT, 32'h0022_1820);
    #1;
    reset = 1'b0;
    #1;
    check("async_after", bus.instruction_OUTPUT, 32'h0022_1820);
    step(32'd10, 32'h342D_0F0F, "async_reload");

    // Mid-cycle change of PC_INPUT: only the value at the edge counts.
    step(32'd3, 32'h0022_3824, "mid_load3");
    bus.PC_INPUT = 32'd3;
    #2;
    bus.PC_INPUT = 32'd4;
    #1;
    check("mid_hold", bus.instruction_OUTPUT, 32'h0022_3824);
    step(32'd4, 32'h0022_4025, "mid_load4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_imem_fetch.md
# pc_imem_fetch

Instruction-fetch front end for the single-cycle MIPS-style datapath. It holds a 32-bit program counter register (`PC`) and drives its value directly into a word-addressed, read-only instruction memory (`IMEN`), which returns one 32-bit instruction per address. The next-PC value is computed outside the block, for example by an incrementer (+1 per word) or branch logic, and enters through `PC_INPUT`.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit words in the instruction memory.

Ports:
- `clk`  input  1: single clock; the PC register updates on the rising edge.
- `reset`  input  1: asynchronous, active-high; clears the PC to 0.
- `PC_INPUT`  input  32: next-PC value, loaded into the PC on every rising `clk` edge while `reset` is low.
- `instruction_OUTPUT`  output  32: instruction word stored at address current_pc.

## Operation
- The PC register (current_pc, internal, 32 bits) loads `PC_INPUT` unconditionally on each rising `clk` edge. There is no enable and no hold input.
- The PC register is forced to 0 immediately whenever `reset` is high, independent of `clk`.
- current_pc is a word index, not a byte address. Address N selects memory word N, so sequential execution advances by +1.
- The instruction memory is a combinational ROM: `instruction_OUTPUT` = mem[current_pc].
- If current_pc ≥ `DEPTH`, `instruction_OUTPUT` = 0x00000000 (nop). The address does not wrap.
- ROM contents are fixed at elaboration. Words 0–11:
  - 0: 0x00221820 (add $3,$1,$2)
  - 1: 0x2109000A (addi $9,$8,10)
  - 2: 0x00853022 (sub $6,$4,$5)
  - 3: 0x00223824 (and $7,$1,$2)
  - 4: 0x00224025 (or $8,$1,$2)
  - 5: 0x0022502A (slt $10,$1,$2)
  - 6: 0x8C0B0004 (lw $11,4($0))
  - 7: 0xAC0B0008 (sw $11,8($0))
  - 8: 0x10220002 (beq $1,$2,+2)
  - 9: 0x302C00FF (andi $12,$1,0xFF)
  - 10: 0x342D0F0F (ori $13,$1,0x0F0F)
  - 11: 0x282E0005 (slti $14,$1,5)
- All words from 12 to `DEPTH`-1 are 0x00000000.
- Field layout used by downstream decode, and by bench printout:
  - opcode [31:26], rs [25:21], rt [20:16].
  - R-type (opcode 0): rd [15:11], shamt [10:6], funct [5:0].
  - Otherwise: immediate [15:0].
- The block performs no decoding itself.

## Timing
- Reset values: current_pc = 0, so `instruction_OUTPUT` = 0x00221820 while `reset` is high.
- PC latency: 1 cycle. `PC_INPUT` is sampled at rising edge k, and current_pc takes that value just after edge k.
- Instruction latency: 0 cycles from current_pc. `instruction_OUTPUT` is combinational and settles within the same cycle that current_pc changes.
- `PC_INPUT` may change at any time between edges. Only its value at the rising edge matters.
- Reset asserted mid-run: the PC clears at once, without waiting for an edge, and `instruction_OUTPUT` returns to word 0.
- Reset released: the first rising edge after release loads `PC_INPUT`.
- Reset held across an edge: the PC stays 0 and `PC_INPUT` is ignored.
- Reset and a clock edge at the same time: reset wins.
- The 32-bit PC register itself wraps modulo 2^32. No overflow flag.

## Test plan
- Reset: hold `reset`=1 with `PC_INPUT`=5 across two edges. Required: `instruction_OUTPUT`=0x00221820 throughout. Release reset; after the next edge `instruction_OUTPUT`=0x0022502A.
- Sequential fetch: from reset, drive `PC_INPUT`=current+1 on every cycle for 16 cycles. Required outputs, in order: 0x00221820, 0x2109000A, 0x00853022, 0x00223824, 0x00224025, 0x0022502A, 0x8C0B0004, 0xAC0B0008, 0x10220002, 0x302C00FF, 0x342D0F0F, 0x282E0005, then 0x00000000 four times.
- Non-sequential jump: load `PC_INPUT`=9, then 1, then 6. Required: 0x302C00FF, 0x2109000A, 0x8C0B0004, each one edge after the corresponding input.
- Out of range: load `PC_INPUT`=64, then 0xFFFFFFFF. Required: `instruction_OUTPUT`=0 for both. Then load 2. Required: 0x00853022.
- Asynchronous reset mid-run: with current_pc=7, pulse `reset` high for 2 ns between clock edges. Required: `instruction_OUTPUT` changes to 0x00221820 during the pulse, before the next edge.
- Mid-cycle input change: change `PC_INPUT` from 3 to 4 between edges. Required: the PC loads 4 at the following edge. `instruction_OUTPUT` does not change until that edge.
